// File: rtl/mem_cmd_executor_pkg.sv
// rtl/mem_cmd_executor_pkg.sv - shared command type, controller opcodes and executor states
package mem_cmd_executor_pkg;

  typedef struct packed {
    logic        read_not_write;
    logic [31:0] length;
    logic [31:0] address;
  } mem_command_t;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_DRAIN
  } exec_state_t;

endpackage

// File: rtl/mem_rd_return_fifo.sv
// rtl/mem_rd_return_fifo.sv - first-word-fall-through buffer for controller read returns
module mem_rd_return_fifo #(
  parameter int width     = 32,
  parameter int log_depth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [width-1:0]     push_data,
  input  logic                 pop,
  output logic                 valid,
  output logic [width-1:0]     head,
  output logic [log_depth:0]   count
);

  localparam int DEPTH = 2 ** log_depth;

  logic [width-1:0]     mem [DEPTH];
  logic [log_depth-1:0] wr_ptr;
  logic [log_depth-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  // A full buffer only accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push && ((count != (log_depth+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_cmd_executor.sv
// rtl/mem_cmd_executor.sv - executes FIFO memory commands as single-word MIG app transactions
module mem_cmd_executor
  import mem_cmd_executor_pkg::*;
#(
  parameter int mem_width      = 32,
  parameter int app_addr_width = 28,
  parameter int addr_shift     = 2,
  parameter int rd_log_depth   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_enable,
  input  logic [64:0]               cmd_data,
  output logic                      cmd_ready,
  input  logic                      wr_enable,
  input  logic [mem_width-1:0]      wr_data,
  output logic                      wr_ready,
  input  logic                      rd_ready,
  output logic                      rd_enable,
  output logic [mem_width-1:0]      rd_data,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [app_addr_width-1:0] app_addr,
  input  logic                      app_rdy,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [mem_width-1:0]      app_wdf_data,
  input  logic                      app_wdf_rdy,
  input  logic [mem_width-1:0]      app_rd_data,
  input  logic                      app_rd_data_valid,
  output logic                      busy,
  output logic                      err_unexpected
);

  exec_state_t           state;
  mem_command_t          cmd;
  logic                  running;
  logic [31:0]           cmd_addr;
  logic [31:0]           cmd_len;
  logic [31:0]           word_idx;
  logic [31:0]           word_addr;
  logic [rd_log_depth:0] outstanding;
  logic [rd_log_depth:0] buffered;
  logic [rd_log_depth+1:0] in_flight;
  logic                  credit_ok;
  logic                  last_word;
  logic                  wr_fire;
  logic                  rd_issue_en;
  logic                  rd_fire;
  logic                  ret_ok;

  assign cmd       = mem_command_t'(cmd_data);
  assign last_word = (word_idx == cmd_len - 32'd1);
  assign word_addr = cmd_addr + word_idx;
  assign app_addr  = app_addr_width'({32'd0, word_addr} << addr_shift);

  // Credit covers both in-flight reads and words parked in the buffer, so returns never overflow it.
  assign in_flight = {1'b0, outstanding} + {1'b0, buffered};
  assign credit_ok = in_flight < (rd_log_depth+2)'(2 ** rd_log_depth);

  assign cmd_ready    = running && (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign wr_ready     = (state == ST_WR_ISSUE) && app_rdy && app_wdf_rdy;
  assign wr_fire      = wr_enable && wr_ready;
  assign rd_issue_en  = (state == ST_RD_ISSUE) && credit_ok;
  assign rd_fire      = rd_issue_en && app_rdy;
  assign app_en       = wr_fire || rd_issue_en;
  assign app_cmd      = (state == ST_RD_ISSUE) ? APP_CMD_READ : APP_CMD_WRITE;
  assign app_wdf_wren = wr_fire;
  assign app_wdf_end  = wr_fire;
  assign app_wdf_data = wr_data;
  assign ret_ok       = app_rd_data_valid && (outstanding != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      running        <= 1'b0;
      cmd_addr       <= '0;
      cmd_len        <= '0;
      word_idx       <= '0;
      outstanding    <= '0;
      err_unexpected <= 1'b0;
    end else begin
      running <= 1'b1;
      if (app_rd_data_valid && (outstanding == '0)) err_unexpected <= 1'b1;

      case ({rd_fire, ret_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        ST_IDLE: begin
          if (cmd_enable && cmd_ready) begin
            cmd_addr <= cmd.address;
            cmd_len  <= cmd.length;
            word_idx <= '0;
            if (cmd.length != '0)
              state <= cmd.read_not_write ? ST_RD_ISSUE : ST_WR_ISSUE;
          end
        end
        ST_WR_ISSUE: begin
          if (wr_fire) begin
            word_idx <= word_idx + 32'd1;
            if (last_word) state <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          if (rd_fire) begin
            word_idx <= word_idx + 32'd1;
            if (last_word) state <= ST_RD_DRAIN;
          end
        end
        ST_RD_DRAIN: begin
          // Holding here keeps a following write from overtaking read returns.
          if (outstanding == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_rd_return_fifo #(
    .width     (mem_width),
    .log_depth (rd_log_depth)
  ) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_ok),
    .push_data (app_rd_data),
    .pop       (rd_ready),
    .valid     (rd_enable),
    .head      (rd_data),
    .count     (buffered)
  );

endmodule
